// File: rtl/cpu_pkg.sv
// Shared types and encodings for the accumulator CPU control sequencer.
// Optional single-step gating of F0 is built with CPU_SEQ_SINGLE_STEP_EN.
package cpu_pkg;

  typedef enum logic [3:0] {
    F0, F1, DEC, IND, E0, E1, E2, RR, HALT
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RR  = 3'd7;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_CMA  = 3'd3;
  localparam logic [2:0] ALU_INC  = 3'd4;

  localparam logic [1:0] AR_SEL_PC  = 2'd0;
  localparam logic [1:0] AR_SEL_IR  = 2'd1;
  localparam logic [1:0] AR_SEL_MEM = 2'd2;

  localparam logic [1:0] BUS_AC = 2'd0;
  localparam logic [1:0] BUS_DR = 2'd1;
  localparam logic [1:0] BUS_PC = 2'd2;

  localparam int RR_CLA = 11;
  localparam int RR_CMA = 9;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_HLT = 0;

  typedef struct packed {
    logic cla;
    logic cma;
    logic inc;
    logic skip;
    logic hlt;
  } rr_act_t;

endpackage

// File: rtl/cpu_rr_decode.sv
// Priority decode of a register-reference instruction into one action.
// Skip conditions are resolved against the accumulator flags here.
module cpu_rr_decode
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] rr,
  input  logic              ac_zero,
  input  logic              ac_sign,
  output rr_act_t           act
);

  logic unused_rr;
  assign unused_rr = ^{rr[10], rr[8:6], rr[1]};

  always_comb begin
    act = '0;
    if (rr[RR_CLA])      act.cla  = 1'b1;
    else if (rr[RR_CMA]) act.cma  = 1'b1;
    else if (rr[RR_INC]) act.inc  = 1'b1;
    else if (rr[RR_SPA]) act.skip = !ac_sign;
    else if (rr[RR_SNA]) act.skip = ac_sign;
    else if (rr[RR_SZA]) act.skip = ac_zero;
    else if (rr[RR_HLT]) act.hlt  = 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/indirect/execute control FSM for the accumulator CPU.
// Define CPU_SEQ_SINGLE_STEP_EN to add a STEP input gating F0.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                REST,
  input  logic [15:0]         IR,
  input  logic                AC_ZERO,
  input  logic                AC_SIGN,
  input  logic                DR_ZERO,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic                STEP,
`endif
  output logic                AR_LOAD,
  output logic [1:0]          AR_SEL,
  output logic                PC_LOAD,
  output logic                PC_INC,
  output logic                IR_LOAD,
  output logic                DR_LOAD,
  output logic                DR_INC,
  output logic                AC_LOAD,
  output logic                AC_CLR,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                MEM_RD,
  output logic                MEM_WR,
  output logic [1:0]          BUS_SEL,
  output logic                HALTED
);

  state_t     st, nxt;
  logic [2:0] op_q;
  logic       i_q;
  logic [2:0] alu;
  rr_act_t    rr;

  cpu_rr_decode #(.ADDR_W(ADDR_W)) u_rr (
    .rr      (IR[ADDR_W-1:0]),
    .ac_zero (AC_ZERO),
    .ac_sign (AC_SIGN),
    .act     (rr)
  );

  always_ff @(posedge clk) begin
    if (REST) begin
      st   <= F0;
      op_q <= OP_AND;
      i_q  <= 1'b0;
    end else begin
      st <= nxt;
      if (st == DEC) begin
        op_q <= IR[14:12];
        i_q  <= IR[15];
      end
    end
  end

  assign ALU_OP = ALU_OP_W'(alu);

  // REST masks every output so the reset cycle is always quiet
  always_comb begin
    nxt     = st;
    AR_LOAD = 1'b0;
    AR_SEL  = AR_SEL_PC;
    PC_LOAD = 1'b0;
    PC_INC  = 1'b0;
    IR_LOAD = 1'b0;
    DR_LOAD = 1'b0;
    DR_INC  = 1'b0;
    AC_LOAD = 1'b0;
    AC_CLR  = 1'b0;
    alu     = ALU_PASS;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    BUS_SEL = BUS_AC;
    HALTED  = 1'b0;
    if (!REST) begin
      unique case (st)
        F0: begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
          if (STEP) begin
            AR_LOAD = 1'b1;
            nxt     = F1;
          end
`else
          AR_LOAD = 1'b1;
          nxt     = F1;
`endif
        end
        F1: begin
          MEM_RD  = 1'b1;
          IR_LOAD = 1'b1;
          PC_INC  = 1'b1;
          nxt     = DEC;
        end
        DEC: begin
          if (IR[14:12] == OP_RR) begin
            nxt = RR;
          end else begin
            AR_LOAD = 1'b1;
            AR_SEL  = AR_SEL_IR;
            nxt     = IR[15] ? IND : E0;
          end
        end
        IND: begin
          MEM_RD  = i_q;
          AR_LOAD = i_q;
          AR_SEL  = AR_SEL_MEM;
          nxt     = E0;
        end
        E0: begin
          nxt = F0;
          case (op_q)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              MEM_RD  = 1'b1;
              DR_LOAD = 1'b1;
              nxt     = E1;
            end
            OP_STA: begin
              MEM_WR  = 1'b1;
              BUS_SEL = BUS_AC;
            end
            OP_BUN: PC_LOAD = 1'b1;
            OP_BSA: begin
              MEM_WR  = 1'b1;
              BUS_SEL = BUS_PC;
              nxt     = E1;
            end
            default: ;
          endcase
        end
        E1: begin
          nxt = F0;
          case (op_q)
            OP_AND: begin
              AC_LOAD = 1'b1;
              alu     = ALU_AND;
            end
            OP_ADD: begin
              AC_LOAD = 1'b1;
              alu     = ALU_ADD;
            end
            OP_LDA: AC_LOAD = 1'b1;
            OP_BSA: PC_LOAD = 1'b1;
            OP_ISZ: begin
              DR_INC = 1'b1;
              nxt    = E2;
            end
            default: ;
          endcase
        end
        E2: begin
          MEM_WR  = 1'b1;
          BUS_SEL = BUS_DR;
          PC_INC  = DR_ZERO;
          nxt     = F0;
        end
        RR: begin
          AC_CLR  = rr.cla;
          AC_LOAD = rr.cma | rr.inc;
          alu     = rr.cma ? ALU_CMA : (rr.inc ? ALU_INC : ALU_PASS);
          PC_INC  = rr.skip;
          nxt     = rr.hlt ? HALT : F0;
        end
        HALT: HALTED = 1'b1;
        default: nxt = F0;
      endcase
    end
  end

endmodule
